// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: sequences an external fifomem RAM and hides its
// registered read latency behind a 2-entry output skid buffer.
module fifo_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned AFULL_TH = (1 << ADDR_W) - 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W+1:0] level,
    output logic              almost_full,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_wclken,
    output logic              mem_wfull,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_rclken,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LVL_W = ADDR_W + 2;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic [DATA_W-1:0] skid0_q, skid0_d;
    logic [DATA_W-1:0] skid1_q, skid1_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              almost_full_q, almost_full_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic              clr_c;
    logic              wr_c;
    logic              pop_c;
    logic              rd_issue_c;
    logic [1:0]        occ_c;
    logic [1:0]        cnt_tmp_c;

    // Handshake and read-issue strobes; clear cycles suppress all of them.
    always_comb begin
        clr_c      = rst | flush;
        wr_c       = in_valid & in_ready_q & ~clr_c;
        pop_c      = out_valid_q & out_ready & ~clr_c;
        occ_c      = skid_cnt_q + 2'(rd_pend_q) - 2'(pop_c);
        rd_issue_c = (mem_cnt_q != '0) && (occ_c < 2'd2) && !clr_c;
    end

    // Next-state: pointers, RAM count, in-flight read, skid buffer, status.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_cnt_d  = mem_cnt_q;
        rd_pend_d  = rd_issue_c;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        cnt_tmp_c  = skid_cnt_q;

        if (wr_c) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (rd_issue_c) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end
        case ({wr_c, rd_issue_c})
            2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase

        // Pop shifts first, then the returning RAM word lands at the tail.
        if (pop_c) begin
            if (skid_cnt_q == 2'd2) begin
                skid0_d = skid1_q;
            end
            cnt_tmp_c = skid_cnt_q - 2'd1;
        end
        if (rd_pend_q && !clr_c) begin
            if (cnt_tmp_c == 2'd0) begin
                skid0_d = mem_rdata;
            end else begin
                skid1_d = mem_rdata;
            end
            cnt_tmp_c = cnt_tmp_c + 2'd1;
        end
        skid_cnt_d = cnt_tmp_c;

        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            mem_cnt_d  = '0;
            rd_pend_d  = 1'b0;
            skid_cnt_d = 2'd0;
        end

        out_valid_d   = (skid_cnt_d != 2'd0);
        in_ready_d    = (mem_cnt_d != CNT_W'(DEPTH));
        level_d       = LVL_W'(mem_cnt_d) + LVL_W'(rd_pend_d) + LVL_W'(skid_cnt_d);
        almost_full_d = (level_d >= LVL_W'(AFULL_TH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            mem_cnt_q     <= '0;
            rd_pend_q     <= 1'b0;
            skid_cnt_q    <= 2'd0;
            skid0_q       <= '0;
            skid1_q       <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            mem_cnt_q     <= mem_cnt_d;
            rd_pend_q     <= rd_pend_d;
            skid_cnt_q    <= skid_cnt_d;
            skid0_q       <= skid0_d;
            skid1_q       <= skid1_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = skid0_q;
    assign level       = level_q;
    assign almost_full = almost_full_q;
    assign mem_wdata   = in_data;
    assign mem_waddr   = wptr_q;
    assign mem_wclken  = wr_c;
    assign mem_wfull   = 1'b0;
    assign mem_raddr   = rptr_q;
    assign mem_rclken  = rd_issue_c;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a small DEPTH=8 memory and a registered-read RAM model.
module tb_fifo_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W+1:0] level;
    logic              almost_full;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_wclken;
    logic              mem_wfull;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_rclken;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [1 << ADDR_W];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              stall_seen = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .almost_full(almost_full),
        .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_wclken(mem_wclken),
        .mem_wfull(mem_wfull), .mem_raddr(mem_raddr), .mem_rclken(mem_rclken),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // fifomem behaviour: synchronous write, registered read
    always_ff @(posedge clk) begin
        if (mem_wclken && !mem_wfull) ram[mem_waddr] <= mem_wdata;
        if (mem_rclken) mem_rdata <= ram[mem_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int unsigned max_cyc);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < int'(max_cyc); i++) begin
            @(negedge clk);
            if (level == '0 && !out_valid) break;
            step();
        end
        @(negedge clk);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: accepted words go into the scoreboard, popped words are compared.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_seen) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(stall_data));
            end
            stall_seen = 1'b0;
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL pop_unexpected: got 0x%0h, expected no word", out_data);
                    end else begin
                        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(in_data);
                if (out_valid && !out_ready) begin
                    stall_seen = 1'b1;
                    stall_data = out_data;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned waited;

        // Power-on reset
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("por_out_valid", 32'(out_valid), 32'd0);
        chk("por_level", 32'(level), 32'd0);
        chk("por_in_ready", 32'(in_ready), 32'd1);
        chk("por_almost_full", 32'(almost_full), 32'd0);

        // Reset mid-traffic
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            in_valid = 1'b1;
            in_data  = 16'(16'h100 + i);
        end
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);

        // Latency into an empty FIFO
        step();
        in_valid  = 1'b1;
        in_data   = 16'hA5A5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_e0_valid", 32'(out_valid), 32'd0);
        chk("lat_e0_level", 32'(level), 32'd1);
        step();
        @(negedge clk);
        chk("lat_e1_valid", 32'(out_valid), 32'd0);
        chk("lat_e1_level", 32'(level), 32'd1);
        step();
        @(negedge clk);
        chk("lat_e2_valid", 32'(out_valid), 32'd1);
        chk("lat_e2_data", 32'(out_data), 32'hA5A5);
        chk("lat_e2_level", 32'(level), 32'd1);
        step();
        @(negedge clk);
        chk("lat_e3_valid", 32'(out_valid), 32'd0);
        chk("lat_e3_level", 32'(level), 32'd0);

        // Fill: 12 offered, 10 fit (8 in RAM + 2 in skid)
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            in_valid = 1'b1;
            in_data  = 16'(i);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill_level", 32'(level), 32'd10);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_almost_full", 32'(almost_full), 32'd1);
        chk("fill_head", 32'(out_data), 32'd0);
        chk("fill_queue", 32'(exp_q.size()), 32'd10);
        step();
        drain(40);
        chk("fill_in_ready_after", 32'(in_ready), 32'd1);

        // Streaming: one word per cycle after two-cycle prime
        out_ready = 1'b1;
        for (int c = 0; c <= 1003; c++) begin
            step();
            in_valid = (c < 1000);
            in_data  = 16'(16'h4000 + c);
            @(negedge clk);
            if (c < 1000) chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_out_valid", 32'(out_valid), 32'((c >= 3) && (c <= 1002)));
        end
        chk("stream_queue", 32'(exp_q.size()), 32'd0);

        // Random backpressure
        for (int c = 0; c < 5000; c++) begin
            step();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
        end
        step();
        drain(40);

        // almost_full threshold and flush with a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            in_valid = 1'b1;
            in_data  = 16'(16'h200 + i);
        end
        step();
        in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("af_level3", 32'(level), 32'd3);
        chk("af_below", 32'(almost_full), 32'd0);
        step();
        in_valid = 1'b1;
        in_data  = 16'h203;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("af_level4", 32'(level), 32'd4);
        chk("af_at", 32'(almost_full), 32'd1);
        for (int i = 4; i < 6; i++) begin
            step();
            in_valid = 1'b1;
            in_data  = 16'(16'h200 + i);
        end
        step();
        in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("flush_pre_level", 32'(level), 32'd6);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        chk("flush_inflight_level", 32'(level), 32'd5);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_almost_full", 32'(almost_full), 32'd0);
        step();
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 10) begin
            step();
            @(negedge clk);
            waited++;
        end
        chk("flush_next_valid", 32'(out_valid), 32'd1);
        chk("flush_next_data", 32'(out_data), 32'h1234);
        step();
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
